id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Decode-to-execute pipeline register for the five-stage RISC-V core. It captures the decoded instruction fields and control word at the D/E boundary. It inserts bubbles on the hazard unit's `stall` (load-use) and `flush` (taken branch/jump) requests, and freezes on an external `hold`. Its `Rs1E`/`Rs2E`/`AddrModeE` outputs feed the hazard unit's forwarding and stall logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC, register operands, immediate
- `REG_AW`, 5, register index width
- `CNT_WIDTH`, 32, performance counter width (used only with `PERF_COUNTERS_EN`)

Ports:
- `clk` in 1: core clock, all state on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `stall` in 1: load-use stall from hazard unit; inserts a bubble into E
- `flush` in 1: branch/jump flush from hazard unit; inserts a bubble into E
- `hold` in 1: freeze request (e.g. memory wait); E keeps its contents
- `PcD`, `PcPlus4D`, `Rd1D`, `Rd2D`, `ImmExtD` in DATA_WIDTH each: decode data fields
- `Rs1D`, `Rs2D`, `RdD` in REG_AW each: register indices
- `RegWriteD`, `MemWriteD`, `BranchD`, `JumpD`, `ALUSrcD` in 1 each: control bits
- `ResultSrcD` in 2, `ALUControlD` in 4, `AddrModeD` in 3: control fields
- `*E` out, same widths: registered copies of every D input above
- `ValidE` out 1: E holds a real instruction (not a bubble)
- `stall_cnt`, `flush_cnt`, `hold_cnt` out CNT_WIDTH each: event counters

## Operation
- Per-cycle action priority: reset > flush > hold > stall > load.
- Reset (`rst_n`=0): the register loads the bubble value and all counters clear.
- Bubble value:
  - all control bits and fields 0
  - `Rs1E`=`Rs2E`=`RdE`=0
  - `AddrModeE`=3'b111, a non-load code, so the bubble never triggers a load-use stall downstream
  - data fields 0
  - `ValidE`=0
- Flush: the register loads the bubble, regardless of `hold` or `stall` in the same cycle.
- Hold (no flush): all E outputs keep their values. A `stall` in the same cycle is ignored; the same load-use condition re-presents after hold drops.
- Stall (no flush, no hold): the register loads the bubble. The upstream F/D registers freeze; they are outside this block.
- Load (none of the above): all `*E` take the `*D` values and `ValidE`=1.
- Zeroed indices on a bubble guarantee that x0 comparisons in forwarding resolve to "no hazard", because x0 is never written.
- Counters, one increment per cycle and only when `rst_n`=1:
  - `flush_cnt` when `flush`=1
  - `hold_cnt` when `hold`=1 and `flush`=0
  - `stall_cnt` when `stall`=1 and `flush`=0 and `hold`=0
  - At most one counter increments per cycle.
  - Counters wrap modulo 2^CNT_WIDTH.

## Timing
- Latency: 1 cycle, D inputs sampled at edge N appear on E outputs after edge N.
- No combinational path from any input to any output.
- `stall`/`flush`/`hold` act at the same edge they are sampled at. The bubble is visible on E in the cycle after assertion.
- Back-to-back stalls produce consecutive bubbles. Deasserting `stall` loads D at the next edge.
- Reset mid-operation wins over everything. The outputs show the bubble after the first edge with `rst_n`=0.
- Counter outputs are registered and update at the same edge as the pipeline register.

## Configuration
- Macro `PERF_COUNTERS_EN`.
- Defined: the three counters are implemented as described.
- Undefined: no counter flops are generated, and `stall_cnt`, `flush_cnt`, `hold_cnt` are tied to 0. Pipeline behaviour is identical either way.

## Test plan
- Reset then load: release `rst_n` and drive `PcD`=0x100, `RdD`=5, `RegWriteD`=1. After one edge: `PcE`=0x100, `RdE`=5, `RegWriteE`=1, `ValidE`=1. During reset: `ValidE`=0, `AddrModeE`=3'b111.
- Stall: `stall`=1 for 2 cycles with a valid D. Required: 2 bubbles (`RdE`=0, `RegWriteE`=0, `AddrModeE`=3'b111), `stall_cnt`=2, then D loads when `stall` drops.
- Hold: load an instruction, then `hold`=1 for 3 cycles with different D values. Required: E unchanged for all 3 cycles, `hold_cnt`=3.
- Simultaneous events: `flush`=`hold`=`stall`=1 for one cycle. Required: bubble, `flush_cnt`+1, `hold_cnt` and `stall_cnt` unchanged. Then `hold`=`stall`=1: E frozen, `hold_cnt`+1 only.
- Counter wrap: with `PERF_COUNTERS_EN` and CNT_WIDTH=4, apply 17 flush cycles. Required: `flush_cnt`=1.
- Macro off: the same stimulus yields identical E outputs, and all counters stay 0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   Decode-to-execute pipeline register of the five-stage RISC-V core.
//   Captures decoded fields and the control word at the D/E boundary,
//   inserts bubbles on flush (taken branch/jump) and stall (load-use),
//   and freezes on hold. Action priority: reset > flush > hold > stall > load.
//
//   Optional feature macro: PERF_COUNTERS_EN
//     defined   -> stall/flush/hold event counters are implemented
//     undefined -> counter outputs are tied to 0, no counter flops
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   stall, flush, hold          hazard-unit / freeze requests
//   PcD..AddrModeD              decode-stage fields and control bits
//   PcE..AddrModeE              registered copies for the execute stage
//   ValidE                      E holds a real instruction (not a bubble)
//   stall_cnt/flush_cnt/hold_cnt  event counters (CNT_WIDTH bits, wrapping)
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] PcD,
    input  logic [DATA_WIDTH-1:0] PcPlus4D,
    input  logic [DATA_WIDTH-1:0] Rd1D,
    input  logic [DATA_WIDTH-1:0] Rd2D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    input  logic [REG_AW-1:0]     RdD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic                  ALUSrcD,
    input  logic [1:0]            ResultSrcD,
    input  logic [3:0]            ALUControlD,
    input  logic [2:0]            AddrModeD,
    output logic [DATA_WIDTH-1:0] PcE,
    output logic [DATA_WIDTH-1:0] PcPlus4E,
    output logic [DATA_WIDTH-1:0] Rd1E,
    output logic [DATA_WIDTH-1:0] Rd2E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [REG_AW-1:0]     Rs1E,
    output logic [REG_AW-1:0]     Rs2E,
    output logic [REG_AW-1:0]     RdE,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic                  ALUSrcE,
    output logic [1:0]            ResultSrcE,
    output logic [3:0]            ALUControlE,
    output logic [2:0]            AddrModeE,
    output logic                  ValidE,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt,
    output logic [CNT_WIDTH-1:0]  hold_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
        logic [REG_AW-1:0]     rd;
        logic                  reg_write;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic [1:0]            result_src;
        logic [3:0]            alu_control;
        logic [2:0]            addr_mode;
        logic                  valid;
    } ex_t;

    ex_t ex_d, ex_q;
    ex_t bubble;
    ex_t load;

    always_comb begin
        // Bubble: zeroed indices make forwarding compare against x0 (never
        // written), and addr_mode 3'b111 is a non-load code so a bubble can
        // never cause a load-use stall.
        bubble           = '0;
        bubble.addr_mode = 3'b111;

        load.pc          = PcD;
        load.pc_plus4    = PcPlus4D;
        load.rd1         = Rd1D;
        load.rd2         = Rd2D;
        load.imm_ext     = ImmExtD;
        load.rs1         = Rs1D;
        load.rs2         = Rs2D;
        load.rd          = RdD;
        load.reg_write   = RegWriteD;
        load.mem_write   = MemWriteD;
        load.branch      = BranchD;
        load.jump        = JumpD;
        load.alu_src     = ALUSrcD;
        load.result_src  = ResultSrcD;
        load.alu_control = ALUControlD;
        load.addr_mode   = AddrModeD;
        load.valid       = 1'b1;

        // A stall under hold is dropped; the load-use condition re-presents
        // once hold releases.
        ex_d = load;
        if (flush) begin
            ex_d = bubble;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (stall) begin
            ex_d = bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign PcE         = ex_q.pc;
    assign PcPlus4E    = ex_q.pc_plus4;
    assign Rd1E        = ex_q.rd1;
    assign Rd2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm_ext;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign BranchE     = ex_q.branch;
    assign JumpE       = ex_q.jump;
    assign ALUSrcE     = ex_q.alu_src;
    assign ResultSrcE  = ex_q.result_src;
    assign ALUControlE = ex_q.alu_control;
    assign AddrModeE   = ex_q.addr_mode;
    assign ValidE      = ex_q.valid;

`ifdef PERF_COUNTERS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d, flush_cnt_q;
    logic [CNT_WIDTH-1:0] hold_cnt_d,  hold_cnt_q;

    // Same priority as the pipeline action, so at most one counter moves.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (hold) begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign hold_cnt  = hold_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign hold_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg. Counters are instantiated 4 bits wide
// so the wrap case is reachable; expected counter values are 0 when
// PERF_COUNTERS_EN is not defined.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, hold;
    logic [31:0] PcD, PcPlus4D, Rd1D, Rd2D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  AddrModeD;
    logic [31:0] PcE, PcPlus4E, Rd1E, Rd2E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  AddrModeE;
    logic        ValidE;
    logic [3:0]  stall_cnt, flush_cnt, hold_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_WIDTH(32), .REG_AW(5), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .hold(hold),
        .PcD(PcD), .PcPlus4D(PcPlus4D), .Rd1D(Rd1D), .Rd2D(Rd2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .JumpD(JumpD), .ALUSrcD(ALUSrcD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .AddrModeD(AddrModeD),
        .PcE(PcE), .PcPlus4E(PcPlus4E), .Rd1E(Rd1E), .Rd2E(Rd2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .AddrModeE(AddrModeE),
        .ValidE(ValidE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
    );

    function automatic logic [31:0] ec(input int n);
`ifdef PERF_COUNTERS_EN
        return 32'(4'(n));
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic [2:0] am);
        PcD = pc; PcPlus4D = pc + 32'd4; Rd1D = pc ^ 32'hA5A5_0000;
        Rd2D = pc ^ 32'h0000_5A5A; ImmExtD = pc + 32'h10;
        Rs1D = rd + 5'd1; Rs2D = rd + 5'd2; RdD = rd;
        RegWriteD = rw; MemWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b1; ALUSrcD = 1'b1;
        ResultSrcD = 2'b01; ALUControlD = 4'h5; AddrModeD = am;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(ValidE), 32'd0);
        chk({tag, "_rd"}, 32'(RdE), 32'd0);
        chk({tag, "_rs1"}, 32'(Rs1E), 32'd0);
        chk({tag, "_regw"}, 32'(RegWriteE), 32'd0);
        chk({tag, "_memw"}, 32'(MemWriteE), 32'd0);
        chk({tag, "_am"}, 32'(AddrModeE), 32'd7);
        chk({tag, "_pc"}, PcE, 32'd0);
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f, input int h);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), ec(s));
        chk({tag, "_flush_cnt"}, 32'(flush_cnt), ec(f));
        chk({tag, "_hold_cnt"}, 32'(hold_cnt), ec(h));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; hold = 1'b0;
        drive(32'h0000_0999, 5'd9, 1'b1, 3'b010);
        step();
        step();
        chk_bubble("reset");
        chk_cnt("reset", 0, 0, 0);

        // Reset release then load
        rst_n = 1'b1;
        drive(32'h0000_0100, 5'd5, 1'b1, 3'b010);
        step();
        chk("load_pc", PcE, 32'h100);
        chk("load_pc4", PcPlus4E, 32'h104);
        chk("load_rd1", Rd1E, 32'hA5A5_0100);
        chk("load_rd2", Rd2E, 32'h0000_5B5A);
        chk("load_imm", ImmExtE, 32'h110);
        chk("load_rd", 32'(RdE), 32'd5);
        chk("load_rs1", 32'(Rs1E), 32'd6);
        chk("load_rs2", 32'(Rs2E), 32'd7);
        chk("load_regw", 32'(RegWriteE), 32'd1);
        chk("load_ctl", {27'd0, MemWriteE, BranchE, JumpE, ALUSrcE, 1'b0}, 32'h1E);
        chk("load_rsrc", 32'(ResultSrcE), 32'd1);
        chk("load_aluc", 32'(ALUControlE), 32'd5);
        chk("load_am", 32'(AddrModeE), 32'd2);
        chk("load_valid", 32'(ValidE), 32'd1);

        // Two stall cycles then release
        drive(32'h0000_0104, 5'd6, 1'b1, 3'b000);
        stall = 1'b1;
        step();
        chk_bubble("stall1");
        chk_cnt("stall1", 1, 0, 0);
        step();
        chk_bubble("stall2");
        chk_cnt("stall2", 2, 0, 0);
        stall = 1'b0;
        step();
        chk("unstall_pc", PcE, 32'h104);
        chk("unstall_rd", 32'(RdE), 32'd6);
        chk("unstall_am", 32'(AddrModeE), 32'd0);
        chk("unstall_valid", 32'(ValidE), 32'd1);

        // Hold for 3 cycles with changing D
        drive(32'h0000_0200, 5'd7, 1'b1, 3'b001);
        step();
        chk("hold_pre_pc", PcE, 32'h200);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_0300 + 32'(i), 5'd9 + 5'(i), 1'b0, 3'b100);
            step();
            chk("hold_pc", PcE, 32'h200);
            chk("hold_rd", 32'(RdE), 32'd7);
            chk("hold_regw", 32'(RegWriteE), 32'd1);
            chk("hold_am", 32'(AddrModeE), 32'd1);
            chk("hold_valid", 32'(ValidE), 32'd1);
            chk_cnt("hold", 2, 0, i + 1);
        end

        // flush + hold + stall together: flush wins
        flush = 1'b1; stall = 1'b1;
        step();
        chk_bubble("fhs");
        chk_cnt("fhs", 2, 1, 3);

        // Load, then hold + stall: frozen, only hold counts
        flush = 1'b0; hold = 1'b0; stall = 1'b0;
        drive(32'h0000_0400, 5'd3, 1'b1, 3'b011);
        step();
        chk("reload_pc", PcE, 32'h400);
        hold = 1'b1; stall = 1'b1;
        drive(32'h0000_0500, 5'd4, 1'b0, 3'b000);
        step();
        chk("hs_pc", PcE, 32'h400);
        chk("hs_rd", 32'(RdE), 32'd3);
        chk("hs_valid", 32'(ValidE), 32'd1);
        chk_cnt("hs", 2, 1, 4);

        // Mid-operation reset beats hold
        rst_n = 1'b0;
        step();
        chk_bubble("midrst");
        chk_cnt("midrst", 0, 0, 0);

        // 17 flushes: 4-bit counter wraps to 1
        rst_n = 1'b1; hold = 1'b0; stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
        end
        chk_bubble("wrap");
        chk_cnt("wrap", 0, 17, 0);

        // Load resumes after flush drops
        flush = 1'b0;
        drive(32'h0000_0600, 5'd11, 1'b1, 3'b101);
        step();
        chk("post_pc", PcE, 32'h600);
        chk("post_rd", 32'(RdE), 32'd11);
        chk("post_am", 32'(AddrModeE), 32'd5);
        chk("post_valid", 32'(ValidE), 32'd1);
        chk_cnt("post", 0, 17, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
